// File: rtl/oled_pkg.sv
// Shared constants for the SSD1306 byte sequencer: command bytes, the command ROM,
// display geometry and FSM state encodings.
package oled_pkg;

    localparam int unsigned DISP_W     = 128;
    localparam int unsigned DISP_H     = 64;
    localparam int unsigned DISP_PAGES = DISP_H / 8;

    localparam logic [7:0] DISP_OFF    = 8'hAE;
    localparam logic [7:0] DISP_ON     = 8'hAF;
    localparam logic [7:0] SET_COL     = 8'h21;
    localparam logic [7:0] SET_PAGE    = 8'h22;
    localparam logic [7:0] CHARGE_PUMP = 8'h8D;

    localparam int unsigned CMD_COUNT = 31;
    localparam int unsigned INIT_LAST = 24;
    localparam int unsigned WIN_FIRST = 25;
    localparam int unsigned WIN_LAST  = 30;

    // Entries 0..24 are the one-shot init list, 25..30 the per-frame address window.
    localparam logic [7:0] CMD_ROM [CMD_COUNT] = '{
        DISP_OFF, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        CHARGE_PUMP, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, DISP_ON,
        SET_COL, 8'h00, 8'(DISP_W - 1), SET_PAGE, 8'h00, 8'(DISP_PAGES - 1)
    };

    typedef logic [2:0] state_t;
    localparam state_t StPwrup   = 3'd0;
    localparam state_t StCmdSend = 3'd1;
    localparam state_t StAck     = 3'd2;
    localparam state_t StWait    = 3'd3;
    localparam state_t StFbRead  = 3'd4;
    localparam state_t StFbLatch = 3'd5;
    localparam state_t StIdle    = 3'd6;

endpackage

// File: rtl/oled_seq_if.sv
// Byte handshake between the OLED sequencer (master) and the I2C byte transmitter (slave).
interface oled_seq_if;

    logic       i2c_start;
    logic       i2c_dcn;
    logic [7:0] i2c_data;
    logic       i2c_busy;

    modport master (
        output i2c_start,
        output i2c_dcn,
        output i2c_data,
        input  i2c_busy
    );

    modport slave (
        input  i2c_start,
        input  i2c_dcn,
        input  i2c_data,
        output i2c_busy
    );

endinterface

// File: rtl/oled_cmd_rom.sv
// Combinational lookup of the SSD1306 init/window command bytes.
module oled_cmd_rom
    import oled_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] data
);

    always_comb begin
        data = 8'h00;
        if (idx < 5'(CMD_COUNT)) begin
            data = CMD_ROM[idx];
        end
    end

endmodule

// File: rtl/oled_seq.sv
// SSD1306 byte sequencer: power-up wait, one-shot init list, then address window plus
// framebuffer streaming, one transmitter transaction per byte.
module oled_seq
    import oled_pkg::*;
#(
    parameter int unsigned PWRUP_CYCLES = 1_200_000,
    parameter int unsigned FB_BYTES     = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        refresh,
    output logic [$clog2(FB_BYTES)-1:0] fb_addr,
    input  logic [7:0]                  fb_data,
    oled_seq_if.master                  i2c,
    output logic                        init_done,
    output logic                        frame_done
);

    localparam int unsigned AW = $clog2(FB_BYTES);
    localparam int unsigned CW = $clog2(PWRUP_CYCLES + 2);

    state_t          state_q, state_d;
    logic [CW-1:0]   pwr_cnt_q, pwr_cnt_d;
    logic [4:0]      cmd_idx_q, cmd_idx_d;
    logic [AW-1:0]   fb_addr_q, fb_addr_d;
    logic [7:0]      data_q, data_d;
    logic            dcn_q, dcn_d;
    logic            start_q, start_d;
    logic            init_done_q, init_done_d;
    logic            frame_done_q, frame_done_d;
    logic            data_phase_q, data_phase_d;
    logic [7:0]      rom_byte;

    oled_cmd_rom u_rom (
        .idx  (cmd_idx_q),
        .data (rom_byte)
    );

    always_comb begin
        state_d      = state_q;
        pwr_cnt_d    = pwr_cnt_q;
        cmd_idx_d    = cmd_idx_q;
        fb_addr_d    = fb_addr_q;
        data_d       = data_q;
        dcn_d        = dcn_q;
        start_d      = start_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        data_phase_d = data_phase_q;

        case (state_q)
            StPwrup: begin
                // The transmitter is not reset with us; never start over a transfer in flight.
                if (pwr_cnt_q != CW'(PWRUP_CYCLES)) begin
                    pwr_cnt_d = pwr_cnt_q + 1'b1;
                end else if (!i2c.i2c_busy) begin
                    cmd_idx_d = 5'd0;
                    state_d   = StCmdSend;
                end
            end
            StCmdSend: begin
                data_d  = rom_byte;
                dcn_d   = 1'b0;
                start_d = 1'b1;
                state_d = StAck;
            end
            StAck: begin
                if (i2c.i2c_busy) begin
                    start_d = 1'b0;
                    state_d = StWait;
                end
            end
            StWait: begin
                if (!i2c.i2c_busy) begin
                    if (!data_phase_q) begin
                        if (cmd_idx_q == 5'(INIT_LAST)) begin
                            init_done_d = 1'b1;
                        end
                        if (cmd_idx_q == 5'(WIN_LAST)) begin
                            fb_addr_d    = '0;
                            data_phase_d = 1'b1;
                            state_d      = StFbRead;
                        end else begin
                            cmd_idx_d = cmd_idx_q + 5'd1;
                            state_d   = StCmdSend;
                        end
                    end else if (fb_addr_q == AW'(FB_BYTES - 1)) begin
                        frame_done_d = 1'b1;
                        data_phase_d = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        fb_addr_d = fb_addr_q + 1'b1;
                        state_d   = StFbRead;
                    end
                end
            end
            StFbRead: begin
                state_d = StFbLatch;
            end
            StFbLatch: begin
                data_d  = fb_data;
                dcn_d   = 1'b1;
                start_d = 1'b1;
                state_d = StAck;
            end
            StIdle: begin
                if (refresh) begin
                    cmd_idx_d = 5'(WIN_FIRST);
                    state_d   = StCmdSend;
                end
            end
            default: begin
                state_d = StPwrup;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StPwrup;
            pwr_cnt_q    <= '0;
            cmd_idx_q    <= 5'd0;
            fb_addr_q    <= '0;
            data_q       <= 8'h00;
            dcn_q        <= 1'b0;
            start_q      <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            data_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pwr_cnt_q    <= pwr_cnt_d;
            cmd_idx_q    <= cmd_idx_d;
            fb_addr_q    <= fb_addr_d;
            data_q       <= data_d;
            dcn_q        <= dcn_d;
            start_q      <= start_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            data_phase_q <= data_phase_d;
        end
    end

    assign fb_addr       = fb_addr_q;
    assign i2c.i2c_start = start_q;
    assign i2c.i2c_dcn   = dcn_q;
    assign i2c.i2c_data  = data_q;
    assign init_done     = init_done_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_oled_seq.sv
// Bench for oled_seq: behavioural transmitter and framebuffer RAM, byte-stream scoreboard.
module tb_oled_seq;

    localparam int unsigned PWR = 16;
    localparam int unsigned FBN = 1024;

    typedef struct packed {
        logic       dcn;
        logic [9:0] addr;
        logic [7:0] data;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       refresh = 1'b0;
    logic [9:0] fb_addr;
    logic [7:0] fb_data = 8'h00;
    logic       init_done;
    logic       frame_done;
    logic       busy = 1'b1;

    oled_seq_if bus ();
    assign bus.i2c_busy = busy;

    oled_seq #(
        .PWRUP_CYCLES (PWR),
        .FB_BYTES     (FBN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .refresh    (refresh),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .i2c        (bus),
        .init_done  (init_done),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    logic [7:0] cmd_list [31] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14,
        8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF, 8'hD9, 8'hF1,
        8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
    };
    logic [7:0] fb_mem [FBN];

    ent_t got_q[$];
    ent_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   frames = 0;

    // Transmitter model state; starts busy for 100 cycles to mimic a transfer left in flight.
    int         tx_phase = 2;
    int         tx_cnt = 100;
    int         accept_dly = 0;
    int         busy_len = 20;
    logic       drop_chk = 1'b0;
    logic [7:0] cap_data = 8'h00;
    logic       cap_dcn = 1'b0;
    logic [9:0] cap_addr = 10'd0;
    int         first_start_cyc = -1;
    int         busy_fall_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        fb_data <= fb_mem[fb_addr];
    end

    task tx_accept();
        busy     = 1'b1;
        tx_phase = 2;
        tx_cnt   = busy_len;
        drop_chk = 1'b1;
        got_q.push_back({cap_dcn, cap_addr, cap_data});
    endtask

    always @(negedge clk) begin
        if (frame_done) frames++;
        case (tx_phase)
            0: begin
                if (bus.i2c_start) begin
                    if (first_start_cyc < 0) first_start_cyc = cyc;
                    cap_data = bus.i2c_data;
                    cap_dcn  = bus.i2c_dcn;
                    cap_addr = fb_addr;
                    if (accept_dly == 0) begin
                        tx_accept();
                    end else begin
                        tx_phase = 1;
                        tx_cnt   = accept_dly;
                    end
                end
            end
            1: begin
                chk("hold_start", 32'(bus.i2c_start), 32'd1);
                chk("hold_byte", 32'({bus.i2c_dcn, bus.i2c_data}), 32'({cap_dcn, cap_data}));
                tx_cnt--;
                if (tx_cnt <= 0) tx_accept();
            end
            default: begin
                if (drop_chk) chk("start_drop", 32'(bus.i2c_start), 32'd0);
                drop_chk = 1'b0;
                tx_cnt--;
                if (tx_cnt <= 0) begin
                    busy          = 1'b0;
                    tx_phase      = 0;
                    busy_fall_cyc = cyc;
                end
            end
        endcase
    end

    task automatic wait_got(input int n, input int budget, input string tag);
        int k = 0;
        while (got_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (frames < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(frames), 32'(n));
    endtask

    task automatic push_window();
        for (int i = 25; i < 31; i++) exp_q.push_back({1'b0, 10'd0, cmd_list[i]});
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 10'(i), fb_mem[i]});
    endtask

    // Compares the oldest logged bytes against the expected list, then consumes both.
    task automatic check_stream(input string tag);
        int   n = exp_q.size();
        int   bad = 0;
        ent_t g;
        ent_t e;
        chk({tag, "_len"}, 32'(got_q.size() >= n), 32'd1);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            g = got_q[i];
            e = exp_q[i];
            if (g.dcn !== e.dcn || g.data !== e.data || (e.dcn && g.addr !== e.addr)) bad++;
        end
        chk({tag, "_bad_bytes"}, 32'(bad), 32'd0);
        for (int i = 0; i < n && got_q.size() > 0; i++) void'(got_q.pop_front());
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_start"}, 32'(bus.i2c_start), 32'd0);
        chk({tag, "_dcn"}, 32'(bus.i2c_dcn), 32'd0);
        chk({tag, "_data"}, 32'(bus.i2c_data), 32'd0);
        chk({tag, "_addr"}, 32'(fb_addr), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        int rel;
        int hi;
        for (int i = 0; i < FBN; i++) fb_mem[i] = 8'(i);

        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        rel = cyc;

        // Transmitter still busy from before reset: first command waits for it.
        wait_got(1, 400, "first_cmd_wait");
        chk("pwrup_min_gap", 32'((first_start_cyc - rel) >= int'(PWR)), 32'd1);
        chk("start_after_busy", 32'(busy_fall_cyc >= 0 && first_start_cyc > busy_fall_cyc),
            32'd1);

        wait_got(25, 2000, "wait_cmd25");
        chk("init_done_before", 32'(init_done), 32'd0);
        wait_got(26, 200, "wait_cmd26");
        chk("init_done_after", 32'(init_done), 32'd1);
        wait_got(31, 400, "wait_cmd31");
        for (int i = 0; i < 31; i++) exp_q.push_back({1'b0, 10'd0, cmd_list[i]});
        check_stream("cmd_list");

        push_frame(FBN);
        wait_frames(1, 40000, "frame1_done");
        check_stream("frame1");

        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.i2c_start) hi++;
        end
        chk("idle_no_start", 32'(hi), 32'd0);
        chk("idle_no_bytes", 32'(got_q.size()), 32'd0);
        chk("idle_frame_cnt", 32'(frames), 32'd1);
        chk("idle_init_done", 32'(init_done), 32'd1);

        for (int i = 0; i < FBN; i++) fb_mem[i] = 8'($urandom);
        busy_len = 2;
        refresh  = 1'b1;
        push_window();
        push_frame(FBN);
        wait_frames(2, 12000, "frame2_done");
        check_stream("frame2");
        push_window();
        push_frame(FBN);
        wait_frames(3, 12000, "frame3_done");
        check_stream("frame3");

        // Slow acceptance on the first bytes of frame 4.
        accept_dly = 50;
        wait_got(10, 2000, "slow_bytes");
        accept_dly = 0;
        push_window();
        push_frame(FBN);
        wait_frames(4, 12000, "frame4_done");
        check_stream("frame4");

        // Reset while data byte 300 is in flight.
        wait_got(6 + 299, 5000, "frame5_b299");
        busy_len = 40;
        wait_got(6 + 300, 500, "frame5_b300");
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        push_window();
        push_frame(300);
        check_stream("frame5_partial");
        got_q.delete();
        busy_len        = 2;
        first_start_cyc = -1;
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        wait_got(1, 400, "post_rst_first");
        chk("post_rst_pwrup_gap", 32'((first_start_cyc - rel) >= int'(PWR)), 32'd1);
        chk("post_rst_after_busy", 32'(busy_fall_cyc > rel && first_start_cyc > busy_fall_cyc),
            32'd1);
        if (got_q.size() > 0) begin
            chk("post_rst_first_byte", 32'({got_q[0].dcn, got_q[0].data}), 32'({1'b0, 8'hAE}));
        end
        chk("post_rst_init_done", 32'(init_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
